// File: rtl/nibble_ex_pkg.sv
// Shared definitions for the nibble adder exerciser.
//   - ex_state_e  : exerciser FSM states
//   - dly_entry_t : one slot of the expected-value delay line
//   - nib_sum()   : reference 4-bit wrap-around add of a packed {a,b} pair
package nibble_ex_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned IDX_W = 8;

  // Pair whose expected value is corrupted when fault injection is armed.
  localparam logic [IDX_W-1:0] FAULT_PAIR = 8'h35;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } ex_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] pair;
    logic [NIB_W-1:0] expected;
  } dly_entry_t;

  // 5-bit add truncated to 4 bits: a = pair[7:4], b = pair[3:0].
  function automatic logic [NIB_W-1:0] nib_sum(input logic [IDX_W-1:0] pair);
    logic [NIB_W:0] s;
    s = {1'b0, pair[IDX_W-1:NIB_W]} + {1'b0, pair[NIB_W-1:0]};
    return s[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/nibble_ex_delay.sv
// Expected-value delay line for the nibble adder exerciser.
// A DEPTH-deep shift register that advances every clock; the entry written
// on edge k appears on out_entry during the cycle after edge k+DEPTH-1, so
// it is consumed at edge k+DEPTH.
// Ports:
//   clk       : clock
//   reset     : asynchronous active-high clear of all slots
//   in_entry  : {valid, pair, expected} loaded into the first slot
//   out_entry : last slot of the line
module nibble_ex_delay
  import nibble_ex_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dly_entry_t in_entry,
  output dly_entry_t out_entry
);

  dly_entry_t stages [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= in_entry;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign out_entry = stages[DEPTH-1];

endmodule

// File: rtl/nibble_adder_exerciser.sv
// Built-in self-test driver/checker for a registered 4-bit nibble adder.
// Walks all 256 {a,b} operand pairs, compares each returned sum against the
// wrap-around expected value LATENCY+1 clocks later, and reports the result.
// Optional build macro EXERCISER_FAULT_INJECT_EN adds the inject input, which
// corrupts the expected value of pair 8'h35 so the checker can be proven.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-high reset
//   start      : run request, honoured in IDLE or DONE
//   inject     : (macro only) arm fault injection, sampled with start
//   dut_a      : registered operand A to the adder
//   dut_b      : registered operand B to the adder
//   dut_sum    : sum nibble returned by the adder
//   busy       : run in progress (DRIVE or DRAIN)
//   done       : run complete
//   pass       : run complete with no mismatches
//   err_count  : saturating mismatch count of the current run
//   first_fail : {a,b} of the first mismatching pair, 8'h00 if none
module nibble_adder_exerciser
  import nibble_ex_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef EXERCISER_FAULT_INJECT_EN
  input  logic             inject,
`endif
  output logic [NIB_W-1:0] dut_a,
  output logic [NIB_W-1:0] dut_b,
  input  logic [NIB_W-1:0] dut_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail
);

  localparam int unsigned CNT_W      = 3;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY);

  ex_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic             launch, advance, push;
  logic             inject_eff;
  logic             mismatch;
  dly_entry_t       in_entry, out_entry;

  // Operands are the pair index register itself.
  assign dut_a = idx[IDX_W-1:NIB_W];
  assign dut_b = idx[NIB_W-1:0];

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                   state_nxt = DRIVE;
      DRIVE:   if (idx == '1)               state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    if (start)                   state_nxt = DRIVE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state == DRIVE) || (state == DRAIN);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  // ---------------------------------------------------------------------
  // Pair sequencing and expected-value generation
  // ---------------------------------------------------------------------
  always_comb begin
    launch  = start && ((state == IDLE) || (state == DONE));
    advance = (state == DRIVE) && (idx != '1);
    push    = launch || advance;
    idx_nxt = launch ? '0 : idx + 1'b1;
  end

`ifdef EXERCISER_FAULT_INJECT_EN
  logic inject_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inject_q <= 1'b0;
    end else if (launch) begin
      inject_q <= inject;
    end
  end

  // Pair 0 is pushed on the launch edge itself, before inject_q updates.
  assign inject_eff = launch ? inject : inject_q;
`else
  assign inject_eff = 1'b0;
`endif

  always_comb begin
    in_entry.valid    = push;
    in_entry.pair     = idx_nxt;
    in_entry.expected = nib_sum(idx_nxt)
                      ^ {{(NIB_W-1){1'b0}}, (inject_eff && (idx_nxt == FAULT_PAIR))};
  end

  nibble_ex_delay #(
    .DEPTH (LATENCY + 1)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_entry  (in_entry),
    .out_entry (out_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (launch) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  assign mismatch = out_entry.valid && (out_entry.expected != dut_sum);

  // err_count never returns to zero within a run, so zero marks "no
  // mismatch seen yet" for first_fail capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (launch) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
      if (err_count == '0) begin
        first_fail <= out_entry.pair;
      end
    end
  end

endmodule

// File: tb/tb_nibble_adder_exerciser.sv
module tb_nibble_adder_exerciser;

  localparam int LAT      = 1;
  localparam int ERR_W    = 8;
  localparam int RUN_BUSY = 257 + LAT;
  localparam int SAT      = (1 << ERR_W) - 1;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
`ifdef EXERCISER_FAULT_INJECT_EN
  logic             inject = 1'b0;
`endif
  logic [3:0]       dut_a, dut_b, dut_sum;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       first_fail;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_adder_exerciser #(
    .LATENCY (LAT),
    .ERR_W   (ERR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef EXERCISER_FAULT_INJECT_EN
    .inject     (inject),
`endif
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_sum    (dut_sum),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  // Adder under test: ideal or one of several faulty behaviours.
  //   0 ideal, 1 sum bit0 stuck at 0, 2 pair F1 returns 1, 3 sum inverted
  int fault_mode = 0;

  function automatic logic [3:0] adder_fn(input int mode, input logic [7:0] p);
    int s;
    s = (int'(p[7:4]) + int'(p[3:0])) % 16;
    case (mode)
      1: s = s & 14;
      2: if (p == 8'hF1) s = 1;
      3: s = 15 - s;
      default: ;
    endcase
    return 4'(s);
  endfunction

  function automatic int golden(input logic [7:0] p, input bit inj);
    int s;
    s = (int'(p[7:4]) + int'(p[3:0])) % 16;
    if (inj && p == 8'h35) s = s ^ 1;
    return s;
  endfunction

  logic [3:0] pipe [LAT] = '{default: 4'h0};
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= adder_fn(fault_mode, {dut_a, dut_b});
  end
  assign dut_sum = pipe[LAT-1];

  // Behavioural model: a run is "edges since the start edge".
  bit m_run  = 1'b0;
  int m_cyc  = 0;
  int m_mode = 0;
  bit m_inj  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0;
      m_cyc = 0;
    end else if (!(m_run && m_cyc < RUN_BUSY) && start) begin
      m_run  = 1'b1;
      m_cyc  = 0;
      m_mode = fault_mode;
`ifdef EXERCISER_FAULT_INJECT_EN
      m_inj  = inject;
`else
      m_inj  = 1'b0;
`endif
    end else if (m_run && m_cyc < 5000) begin
      m_cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int e_pair, e_err, e_ff, hi;
    bit e_busy, e_done, e_pass;
    #1;
    if (chk_en) begin
      e_pair = 0; e_err = 0; e_ff = 0; e_busy = 0; e_done = 0;
      if (m_run) begin
        e_pair = (m_cyc > 255) ? 255 : m_cyc;
        e_busy = (m_cyc < RUN_BUSY);
        e_done = !e_busy;
        hi = m_cyc - LAT - 1;
        if (hi > 255) hi = 255;
        for (int p = 0; p <= hi; p++) begin
          if (int'(adder_fn(m_mode, 8'(p))) != golden(8'(p), m_inj)) begin
            if (e_err == 0) e_ff = p;
            if (e_err < SAT) e_err++;
          end
        end
      end
      e_pass = e_done && (e_err == 0);
      check("cyc_dut_a",      32'(dut_a),      32'(e_pair / 16));
      check("cyc_dut_b",      32'(dut_b),      32'(e_pair % 16));
      check("cyc_busy",       32'(busy),       32'(e_busy));
      check("cyc_done",       32'(done),       32'(e_done));
      check("cyc_pass",       32'(pass),       32'(e_pass));
      check("cyc_err_count",  32'(err_count),  32'(e_err));
      check("cyc_first_fail", 32'(first_fail), 32'(e_ff));
    end
  end

  // One run: pulse start, optionally poke start again or reset mid-run.
  task automatic run(input int mode, input int poke, input int rst_at,
                     output int busy_cycles, output bit finished);
    bit aborted;
    @(negedge clk);
    fault_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    finished = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < 600 && !finished && !aborted; i++) begin
      if (!busy) begin
        finished = 1'b1;
      end else begin
        busy_cycles++;
        if (busy_cycles == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          @(negedge clk);
          reset = 1'b0;
          aborted = 1'b1;
        end else begin
          start = (busy_cycles == poke);
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
    if (!aborted) check("run_terminated", 32'(finished), 32'd1);
  endtask

  task automatic pin_result(input string tag, input int bc, input int e_err,
                            input int e_ff, input bit e_pass);
    check({tag, "_busy_len"},   32'(bc),         32'(RUN_BUSY));
    check({tag, "_done"},       32'(done),       32'd1);
    check({tag, "_pass"},       32'(pass),       32'(e_pass));
    check({tag, "_err_count"},  32'(err_count),  32'(e_err));
    check({tag, "_first_fail"}, 32'(first_fail), 32'(e_ff));
  endtask

  task automatic pin_zero(input string tag);
    check({tag, "_busy"},       32'(busy),                32'd0);
    check({tag, "_done"},       32'(done),                32'd0);
    check({tag, "_pass"},       32'(pass),                32'd0);
    check({tag, "_operands"},   32'({dut_a, dut_b}),      32'd0);
    check({tag, "_err_count"},  32'(err_count),           32'd0);
    check({tag, "_first_fail"}, 32'(first_fail),          32'd0);
  endtask

  initial begin
    int  bc;
    bit  fin;
    int  mode, poke, rst_at;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    pin_zero("reset");

    run(0, 0, 0, bc, fin);
    pin_result("ideal", bc, 0, 8'h00, 1'b1);

    run(1, 0, 0, bc, fin);
    pin_result("stuck0", bc, 128, 8'h01, 1'b0);

    run(2, 0, 0, bc, fin);
    pin_result("wrapF1", bc, 1, 8'hF1, 1'b0);

    run(3, 0, 0, bc, fin);
    pin_result("invert_sat", bc, SAT, 8'h00, 1'b0);

    run(0, 50, 0, bc, fin);
    pin_result("start_ignored", bc, 0, 8'h00, 1'b1);

    run(1, 0, 100, bc, fin);
    repeat (3) @(negedge clk);
    pin_zero("midrun_reset");

    run(0, 0, 0, bc, fin);
    pin_result("after_reset", bc, 0, 8'h00, 1'b1);

    for (int r = 0; r < 5; r++) begin
      mode   = int'($urandom_range(0, 3));
      poke   = int'($urandom_range(0, RUN_BUSY));
      rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RUN_BUSY)) : 0;
      run(mode, poke, rst_at, bc, fin);
      repeat (2) @(negedge clk);
    end

`ifdef EXERCISER_FAULT_INJECT_EN
    inject = 1'b1;
    run(0, 0, 0, bc, fin);
    inject = 1'b0;
    pin_result("inject_on", bc, 1, 8'h35, 1'b0);

    run(0, 0, 0, bc, fin);
    pin_result("inject_off", bc, 0, 8'h00, 1'b1);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
